// File: rtl/jt12_wrseq.sv
// Host-side write sequencer for the JT12 CPU bus.
// Queues (address, data) register writes in a FIFO and replays each one as an
// address access followed by a data access, then holds off for the chip's busy time.
// Optional macro JT12_WRSEQ_BUSYPOLL_EN replaces the fixed busy wait with status polling.
module jt12_wrseq #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cen_i,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [8:0]                 req_addr_i,
  input  logic [7:0]                 req_data_i,
  output logic [1:0]                 cpu_addr_o,
  output logic [7:0]                 cpu_din_o,
  output logic                       cpu_cs_n_o,
  output logic                       cpu_wr_n_o,
  output logic                       cpu_rd_n_o,
  input  logic [7:0]                 cpu_dout_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       idle_o,
  output logic                       timeout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
`ifdef JT12_WRSEQ_BUSYPOLL_EN
  localparam int unsigned CntMax = 4 * BUSY_CYCLES - 1;
`else
  localparam int unsigned CntMax = BUSY_CYCLES - 1;
`endif
  // +2 keeps the width at least one bit when BUSY_CYCLES is 1
  localparam int unsigned CW = $clog2(CntMax + 2);

  typedef enum logic [2:0] {StIdle, StAddr, StGap1, StData, StWait} state_e;

  // FIFO storage: {a1, reg[7:0], val[7:0]}
  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;
  logic [16:0]   head;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          a1_q;
  logic [7:0]    val_q;
  logic [1:0]    addr_q;
  logic [7:0]    din_q;
  logic          cs_n_q, wr_n_q;
  logic          idle_q;
  logic          fsm_idle_d;

  assign req_ready_o = (level_q != LW'(DEPTH));
  // flush beats a same-edge push; a same-edge pop still hands the head to the FSM
  assign push        = req_valid_i && req_ready_o && !flush_i;
  assign pop         = cen_i && (state_q == StIdle) && (level_q != '0);
  assign head        = mem_q[rd_ptr_q];

`ifdef JT12_WRSEQ_BUSYPOLL_EN
  logic rd_n_q, timeout_q;
  logic poll_ok, poll_to;
  // first poll sample is discarded to cover the chip's read latency
  assign poll_ok = (cnt_q != '0) && !cpu_dout_i[7];
  assign poll_to = (cnt_q == CW'(CntMax));
`endif

  // FIFO occupancy next state
  always_comb begin
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Whether the FSM sits in IDLE after this edge
  always_comb begin
    fsm_idle_d = 1'b0;
    case (state_q)
      StIdle:  fsm_idle_d = !pop;
`ifdef JT12_WRSEQ_BUSYPOLL_EN
      StWait:  fsm_idle_d = cen_i && (poll_ok || poll_to);
`else
      StWait:  fsm_idle_d = cen_i && (cnt_q == '0);
`endif
      default: fsm_idle_d = 1'b0;
    endcase
  end

  // FIFO storage write; no reset needed on the data array
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_addr_i, req_data_i};
    end
  end

  // FIFO pointers, occupancy and idle flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idle_q   <= 1'b1;
    end else begin
      level_q <= level_d;
      idle_q  <= fsm_idle_d && (level_d == '0);
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Bus FSM with registered bus outputs; advances only on cen ticks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a1_q      <= 1'b0;
      val_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
`ifdef JT12_WRSEQ_BUSYPOLL_EN
      rd_n_q    <= 1'b1;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef JT12_WRSEQ_BUSYPOLL_EN
      timeout_q <= 1'b0;
`endif
      if (cen_i) begin
        case (state_q)
          StIdle: begin
            if (pop) begin
              a1_q    <= head[16];
              val_q   <= head[7:0];
              addr_q  <= {head[16], 1'b0};
              din_q   <= head[15:8];
              cs_n_q  <= 1'b0;
              wr_n_q  <= 1'b0;
              state_q <= StAddr;
            end
          end
          StAddr: begin
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            state_q <= StGap1;
          end
          StGap1: begin
            addr_q  <= {a1_q, 1'b1};
            din_q   <= val_q;
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b0;
            state_q <= StData;
          end
          StData: begin
            wr_n_q  <= 1'b1;
            state_q <= StWait;
`ifdef JT12_WRSEQ_BUSYPOLL_EN
            addr_q  <= '0;
            cs_n_q  <= 1'b0;
            rd_n_q  <= 1'b0;
            cnt_q   <= '0;
`else
            cs_n_q  <= 1'b1;
            cnt_q   <= CW'(BUSY_CYCLES - 1);
`endif
          end
          StWait: begin
`ifdef JT12_WRSEQ_BUSYPOLL_EN
            if (poll_ok || poll_to) begin
              cs_n_q    <= 1'b1;
              rd_n_q    <= 1'b1;
              timeout_q <= !poll_ok;
              state_q   <= StIdle;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
`else
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cpu_addr_o = addr_q;
  assign cpu_din_o  = din_q;
  assign cpu_cs_n_o = cs_n_q;
  assign cpu_wr_n_o = wr_n_q;
  assign level_o    = level_q;
  assign idle_o     = idle_q;

`ifdef JT12_WRSEQ_BUSYPOLL_EN
  assign cpu_rd_n_o = rd_n_q;
  assign timeout_o  = timeout_q;
`else
  // status byte is not needed with the fixed busy wait
  logic unused_dout;
  assign unused_dout = ^cpu_dout_i;
  assign cpu_rd_n_o  = 1'b1;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: doc/jt12_wrseq.md
Name: jt12_wrseq

Overview:
Host-side write sequencer for the JT12 CPU bus; it drives the bus that the chip's register decoder and per-operator register file consume.
- Queues (address, data) register writes in a FIFO.
- Replays each write as a two-phase address-then-data access on the chip's cs_n/wr_n/addr/din pins.
- Enforces the post-write busy interval before issuing the next access.
- Sits between a soft-CPU, sound driver or VGM player and the jt12 top.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
BUSY_CYCLES, 32, cen ticks to hold off after each data write; minimum 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cen  input  1  chip clock enable; the bus FSM advances only when cen=1
flush  input  1  synchronous FIFO clear
req_valid  input  1  write request valid
req_ready  output  1  FIFO can accept a request
req_addr  input  9  bit8 = register bank (a1); [7:0] = register number
req_data  input  8  register value
cpu_addr  output  2  chip {a1,a0}
cpu_din  output  8  chip data bus
cpu_cs_n  output  1  chip select, active low
cpu_wr_n  output  1  write strobe, active low
cpu_rd_n  output  1  read strobe, active low
cpu_dout  input  8  chip status byte; bit7 = busy
level  output  $clog2(DEPTH)+1  FIFO occupancy
idle  output  1  FIFO empty and FSM in IDLE
timeout  output  1  one-clk pulse on busy-poll timeout

Behaviour:
Reset (asynchronous, while rst_n=0):
- FIFO is emptied; level=0.
- FSM enters IDLE; the busy counter is cleared.
- cpu_cs_n=1, cpu_wr_n=1, cpu_rd_n=1, cpu_addr=0, cpu_din=0.
- idle=1, timeout=0, req_ready=1.
- Reset asserted mid-transaction aborts that transaction immediately; no strobe stays low.

FIFO:
- Push on every clk edge where req_valid && req_ready; push does not depend on cen.
- req_ready = (level != DEPTH).
- When full, a push is refused even if a pop happens on the same edge.
- A simultaneous push and pop leaves level unchanged.
- Pointers wrap modulo DEPTH.

flush:
- Synchronous; empties the FIFO and sets level=0.
- Does not abort the write already latched in the FSM.
- flush and push on the same edge: flush wins and the pushed entry is dropped.

FSM (all transitions only on cen=1):
- IDLE: if the FIFO is not empty, pop the head into holding registers (a1, reg, val) and go to ADDR. Otherwise stay; all strobes high.
- ADDR (1 tick): cpu_addr={a1,0}, cpu_din=reg, cs_n=0, wr_n=0. Then go to GAP1.
- GAP1 (1 tick): cs_n=1, wr_n=1; cpu_addr and cpu_din hold. Then go to DATA.
- DATA (1 tick): cpu_addr={a1,1}, cpu_din=val, cs_n=0, wr_n=0. Then go to WAIT, loading the counter with BUSY_CYCLES-1.
- WAIT: strobes high; count down once per tick. Go to IDLE on the tick where the counter is 0.

Timing:
- Each write occupies exactly BUSY_CYCLES+3 cen ticks from leaving IDLE to returning to IDLE.
- The next pop happens on the following IDLE tick.
- Outputs are registered and change only on cen ticks; the strobes therefore stay low for a whole cen period.
- idle=1 only when the FSM is in IDLE and level=0. It is evaluated after that edge's push/pop.

Optional Feature:
JT12_WRSEQ_BUSYPOLL_EN
- Defined: WAIT becomes POLL. Each tick drives cpu_addr=0, cs_n=0, rd_n=0 and samples cpu_dout[7] registered on that tick.
  - First sample with bit7=0: go to IDLE (strobes high on that transition).
  - After 4*BUSY_CYCLES ticks without bit7=0: pulse timeout for one clk and go to IDLE.
  - The first sample is ignored, covering the chip's read latency.
- Not defined: fixed WAIT counter as above. cpu_rd_n is tied 1, cpu_dout is unused, timeout is tied 0.

Test Plan:
- Single write 0x028 / 0xF1, cen every 4th clk, BUSY_CYCLES=32:
  - cs_n/wr_n low one tick with addr=0, din=0x28.
  - One high gap.
  - Low one tick with addr=1, din=0xF1.
  - Next activity no earlier than 35 cen ticks after leaving IDLE.
- Write to 0x1A4 / 0x22 -> cpu_addr=2 in the address phase and 3 in the data phase.
- Push 17 entries back-to-back while cen=0, DEPTH=16:
  - req_ready falls after the 16th; the 17th is held by valid and not accepted; level=16.
  - Enabling cen drains all 16 in order with no gaps beyond BUSY_CYCLES+3 ticks each.
- Assert flush in the middle of writing entry 1 of 5 -> entry 1 completes its DATA phase; entries 2-5 never appear; idle=1 after WAIT.
- Drop rst_n during the DATA phase -> cs_n and wr_n go to 1 before the next clk edge; level=0; after release, idle=1 and req_ready=1.
- With JT12_WRSEQ_BUSYPOLL_EN:
  - cpu_dout[7] held 1 for 10 ticks, then 0 -> FSM returns to IDLE on the first 0 sample; timeout stays 0.
  - cpu_dout[7] stuck at 1 -> timeout pulses once after 128 ticks and the FSM continues with the next entry.
